// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, register index width and the
// hazard controller's state encoding.
package rv32i_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; slave is the controller,
// master is the pipeline datapath that feeds it.
interface pipeline_hazard_ctrl_if #(parameter int XLEN = 32);
  import rv32i_pkg::*;

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_mem_rd;
  logic                 id_branch_taken;
  logic                 id_jump;
  logic                 mem_req;
  logic                 mem_ready;
  logic                 pc_en;
  logic                 if_id_en;
  logic                 if_id_flush;
  logic                 id_ex_en;
  logic                 id_ex_flush;
  logic                 ex_mem_en;
  logic                 mem_wb_bubble;
  logic                 pc_redirect;
  logic                 mem_err;
  logic [XLEN-1:0]      stall_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_rd,
           id_branch_taken, id_jump, mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_bubble, pc_redirect, mem_err, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_rd,
           id_branch_taken, id_jump, mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_bubble, pc_redirect, mem_err, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Combinational load-use detector: a load in EX writing a register that
// the ID instruction reads (x0 never creates a hazard).
module load_use_detect
  import rv32i_pkg::*;
(
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  input  logic                 i_id_use_rs1,
  input  logic                 i_id_use_rs2,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic                 i_ex_mem_rd,
  output logic                 o_lu
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1 = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_hit_rs2 = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
  assign o_lu      = i_ex_mem_rd & (i_ex_rd != {REG_IDX_W{1'b0}}) & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze with
// timeout supervision, load-use bubble, and branch/jump squash.
module pipeline_hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [4:0] LP_WCNT_LAST = 5'(TIMEOUT - 1);

  hz_state_t       r_state;
  hz_state_t       w_state_nxt;
  logic [4:0]      r_wcnt;
  logic [4:0]      w_wcnt_nxt;
  logic            r_mem_err;
  logic [XLEN-1:0] r_stall_count;

  logic w_lu;
  logic w_timeout;
  logic w_mem_stall;
  logic w_forced;
  logic w_pc_en;
  logic w_if_id_en;
  logic w_if_id_flush;
  logic w_id_ex_en;
  logic w_id_ex_flush;
  logic w_ex_mem_en;
  logic w_mem_wb_bubble;
  logic w_pc_redirect;

  load_use_detect u_lu (
    .i_id_rs1     (bus.id_rs1),
    .i_id_rs2     (bus.id_rs2),
    .i_id_use_rs1 (bus.id_use_rs1),
    .i_id_use_rs2 (bus.id_use_rs2),
    .i_ex_rd      (bus.ex_rd),
    .i_ex_mem_rd  (bus.ex_mem_rd),
    .o_lu         (w_lu)
  );

  assign w_timeout   = (r_state == ST_MEM_WAIT) & (r_wcnt == LP_WCNT_LAST);
  assign w_mem_stall = bus.mem_req & ~bus.mem_ready & ~w_timeout;
  // Forced release: the access is still outstanding but the wait budget is spent.
  assign w_forced    = w_timeout & bus.mem_req & ~bus.mem_ready;

  // Priority mux for the stage enables, flushes and redirect.
  always_comb begin
    w_pc_en         = 1'b1;
    w_if_id_en      = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_en      = 1'b1;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_en     = 1'b1;
    w_mem_wb_bubble = 1'b0;
    w_pc_redirect   = 1'b0;
    if (rst) begin
      w_pc_en         = 1'b0;
      w_if_id_en      = 1'b0;
      w_if_id_flush   = 1'b1;
      w_id_ex_en      = 1'b0;
      w_id_ex_flush   = 1'b1;
      w_ex_mem_en     = 1'b0;
      w_mem_wb_bubble = 1'b1;
    end else if (w_mem_stall) begin
      w_pc_en         = 1'b0;
      w_if_id_en      = 1'b0;
      w_id_ex_en      = 1'b0;
      w_ex_mem_en     = 1'b0;
      w_mem_wb_bubble = 1'b1;
    end else if (w_lu) begin
      w_pc_en         = 1'b0;
      w_if_id_en      = 1'b0;
      w_id_ex_flush   = 1'b1;
      w_mem_wb_bubble = w_forced;
    end else if (bus.id_branch_taken | bus.id_jump) begin
      w_pc_redirect   = 1'b1;
      w_if_id_flush   = 1'b1;
      w_mem_wb_bubble = w_forced;
    end else begin
      w_mem_wb_bubble = w_forced;
    end
  end

  // FSM next state and wait counter.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      ST_RUN: begin
        w_wcnt_nxt = 5'd0;
        if (w_mem_stall) begin
          w_state_nxt = ST_MEM_WAIT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (w_mem_stall) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wcnt_nxt  = r_wcnt + 5'd1;
        end else begin
          w_state_nxt = ST_RUN;
          w_wcnt_nxt  = 5'd0;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wcnt_nxt  = 5'd0;
      end
    endcase
  end

  // State, sticky error and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wcnt        <= 5'd0;
      r_mem_err     <= 1'b0;
      r_stall_count <= {XLEN{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_forced) begin
        r_mem_err <= 1'b1;
      end
      if (!w_pc_en && (r_stall_count != {XLEN{1'b1}})) begin
        r_stall_count <= r_stall_count + {{(XLEN-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.pc_en         = w_pc_en;
  assign bus.if_id_en      = w_if_id_en;
  assign bus.if_id_flush   = w_if_id_flush;
  assign bus.id_ex_en      = w_id_ex_en;
  assign bus.id_ex_flush   = w_id_ex_flush;
  assign bus.ex_mem_en     = w_ex_mem_en;
  assign bus.mem_wb_bubble = w_mem_wb_bubble;
  assign bus.pc_redirect   = w_pc_redirect;
  assign bus.mem_err       = r_mem_err;
  assign bus.stall_count   = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios then
// randomized traffic against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int XLEN    = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << XLEN) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.XLEN(XLEN)) u_if ();

  pipeline_hazard_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  // ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble, pc_redirect, mem_err}
  typedef struct packed {
    logic [8:0]      ctrl;
    logic [XLEN-1:0] cnt;
  } exp_t;

  localparam logic [8:0] CTRL_RST = 9'b0_0_1_0_1_0_1_0_0;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit m_wait   = 1'b0;
  int m_wcnt   = 0;
  bit m_err    = 1'b0;
  int m_stalls = 0;

  function automatic logic [8:0] dut_ctrl();
    return {u_if.pc_en, u_if.if_id_en, u_if.if_id_flush, u_if.id_ex_en, u_if.id_ex_flush,
            u_if.ex_mem_en, u_if.mem_wb_bubble, u_if.pc_redirect, u_if.mem_err};
  endfunction

  task automatic check(input string name, input logic [8:0] got_c, input logic [8:0] want_c,
                       input logic [XLEN-1:0] got_n, input logic [XLEN-1:0] want_n);
    n_cmp = n_cmp + 2;
    if (got_c !== want_c) begin
      n_bad++;
      $display("FAIL %s ctrl at %0t: got %b want %b", name, $time, got_c, want_c);
    end
    if (got_n !== want_n) begin
      n_bad++;
      $display("FAIL %s stall_count at %0t: got %0d want %0d", name, $time, got_n, want_n);
    end
  endtask

  // One clock of stimulus: drive, predict the response, advance the model.
  task automatic step(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input logic [4:0] rd, input bit ld,
                      input bit br, input bit jp, input bit mrq, input bit mrd);
    exp_t e;
    bit   lu, tmo, stall, forced, pc_en;
    @(negedge clk);
    rst                  = r;
    u_if.id_rs1          = rs1;
    u_if.id_rs2          = rs2;
    u_if.id_use_rs1      = u1;
    u_if.id_use_rs2      = u2;
    u_if.ex_rd           = rd;
    u_if.ex_mem_rd       = ld;
    u_if.id_branch_taken = br;
    u_if.id_jump         = jp;
    u_if.mem_req         = mrq;
    u_if.mem_ready       = mrd;
    if (r) begin
      m_wait = 1'b0; m_wcnt = 0; m_err = 1'b0; m_stalls = 0;
      e.ctrl = CTRL_RST;
      e.cnt  = '0;
      q.push_back(e);
    end else begin
      tmo    = m_wait && (m_wcnt == TIMEOUT - 1);
      stall  = mrq && !mrd && !tmo;
      forced = tmo && mrq && !mrd;
      lu     = ld && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (stall)         e.ctrl = {8'b0000_0010, m_err};
      else if (lu)       e.ctrl = {6'b00_0_1_1_1, forced, 1'b0, m_err};
      else if (br || jp) e.ctrl = {6'b11_1_1_0_1, forced, 1'b1, m_err};
      else               e.ctrl = {6'b11_0_1_0_1, forced, 1'b0, m_err};
      e.cnt = m_stalls[XLEN-1:0];
      q.push_back(e);
      pc_en = !(stall || lu);
      if (!pc_en && m_stalls < CNT_MAX) m_stalls++;
      if (forced) m_err = 1'b1;
      if (stall) begin
        if (m_wait) m_wcnt++;
        else begin m_wait = 1'b1; m_wcnt = 0; end
      end else begin
        m_wait = 1'b0;
        m_wcnt = 0;
      end
    end
  endtask

  task automatic idle(input bit mrq, input bit mrd);
    step(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, mrq, mrd);
  endtask

  // Monitor: outputs are presented every cycle; compare just after the drive edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("scoreboard", dut_ctrl(), e.ctrl, u_if.stall_count, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.id_rs1 = 5'd0; u_if.id_rs2 = 5'd0; u_if.id_use_rs1 = 1'b0; u_if.id_use_rs2 = 1'b0;
    u_if.ex_rd = 5'd0; u_if.ex_mem_rd = 1'b0; u_if.id_branch_taken = 1'b0; u_if.id_jump = 1'b0;
    u_if.mem_req = 1'b0; u_if.mem_ready = 1'b0;

    repeat (2) step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // load-use on rs1, then on rs2, then x0 load
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    step(1'b0, 5'd7, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // taken branch, jump, branch deferred by load-use, ready without request
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 5'd4, 5'd2, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // memory wait: three stalled cycles then ready
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);

    // timeout: request held without ready
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) idle(1'b1, 1'b0);
    repeat (3) idle(1'b0, 1'b0);

    // asynchronous reset between edges while waiting on memory
    repeat (3) idle(1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", dut_ctrl(), CTRL_RST, u_if.stall_count, '0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);

    // randomized traffic; memory requests stay asserted while a wait is pending
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           m_wait ? 1'b1 : ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(negedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
